// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and index helper for the 3x3 matrix multiplier blocks.
// The row-major helper is also used by the operand loader.
package matmul_pkg;

   localparam int ELEM_COUNT = 9;
   localparam int IDX_W      = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   // Flat row-major element index for a (row, col) position in a 3x3 matrix.
   function automatic logic [IDX_W-1:0] rc_to_idx(input int row, input int col);
      return IDX_W'(row * 3 + col);
   endfunction

endpackage

// File: rtl/matrix_result_streamer.sv
// Snapshots the nine multiplier result words on start and streams them row-major
// over a valid/ready interface, one word per handshake, with all outputs registered.
module matrix_result_streamer
   import matmul_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] R00,
   input  logic [DATA_W-1:0] R01,
   input  logic [DATA_W-1:0] R02,
   input  logic [DATA_W-1:0] R10,
   input  logic [DATA_W-1:0] R11,
   input  logic [DATA_W-1:0] R12,
   input  logic [DATA_W-1:0] R20,
   input  logic [DATA_W-1:0] R21,
   input  logic [DATA_W-1:0] R22,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   logic [DATA_W-1:0] r_grid   [3][3];
   logic [DATA_W-1:0] r_flat   [ELEM_COUNT];
   logic [DATA_W-1:0] snap_reg [ELEM_COUNT];

   state_t            state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic [IDX_W-1:0]  idx_next;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_valid_reg;
   logic              out_last_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              overrun_reg;
   logic              capture;

   assign r_grid[0][0] = R00;
   assign r_grid[0][1] = R01;
   assign r_grid[0][2] = R02;
   assign r_grid[1][0] = R10;
   assign r_grid[1][1] = R11;
   assign r_grid[1][2] = R12;
   assign r_grid[2][0] = R20;
   assign r_grid[2][1] = R21;
   assign r_grid[2][2] = R22;

   // Flatten the result grid into stream order.
   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      for (genvar gj = 0; gj < 3; gj++) begin : g_col
         assign r_flat[rc_to_idx(gi, gj)] = r_grid[gi][gj];
      end
   end

   assign capture  = (state_reg == IDLE) && start;
   assign idx_next = idx_reg + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ELEM_COUNT; i++) snap_reg[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < ELEM_COUNT; i++) snap_reg[i] <= r_flat[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  // First word comes straight from the inputs; the snapshot fills on the same edge.
                  state_reg     <= SEND;
                  idx_reg       <= '0;
                  out_data_reg  <= r_flat[0];
                  out_valid_reg <= 1'b1;
                  out_last_reg  <= 1'b0;
                  busy_reg      <= 1'b1;
                  overrun_reg   <= 1'b0;
               end
            end
            SEND: begin
               if (start) overrun_reg <= 1'b1;
               if (idx_reg > LAST_IDX) begin
                  state_reg     <= IDLE;
                  idx_reg       <= '0;
                  out_data_reg  <= '0;
                  out_valid_reg <= 1'b0;
                  out_last_reg  <= 1'b0;
                  busy_reg      <= 1'b0;
               end else if (out_ready) begin
                  if (idx_reg == LAST_IDX) begin
                     state_reg     <= IDLE;
                     idx_reg       <= '0;
                     out_data_reg  <= '0;
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
                  end else begin
                     idx_reg      <= idx_next;
                     out_data_reg <= snap_reg[idx_next];
                     out_last_reg <= (idx_next == LAST_IDX);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_index = idx_reg;
   assign out_last  = out_last_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign overrun   = overrun_reg;

endmodule
